// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// The arbiter never decodes instructions; the opcode fields serve the ALU.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } R_Type;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SR   = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    typedef logic [0:0] req_id_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    // One-hot grant to requester index; zero grant maps to 0.
    function automatic req_id_t grant_to_id(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of the ALU arbiter.
// slave is the arbiter's view; master is the surrounding pipeline's.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);

    logic            req0_valid;
    logic            req1_valid;
    logic            req0_ready;
    logic            req1_ready;
    logic [31:0]     req0_instr;
    logic [31:0]     req1_instr;
    logic [XLEN-1:0] req0_rs1;
    logic [XLEN-1:0] req0_rs2;
    logic [XLEN-1:0] req1_rs1;
    logic [XLEN-1:0] req1_rs2;

    logic [31:0]     alu_instr;
    logic [XLEN-1:0] alu_rs1;
    logic [XLEN-1:0] alu_rs2;
    logic [XLEN-1:0] alu_result;

    logic            rsp_valid;
    logic            rsp_ready;
    req_id_t         rsp_id;
    logic [XLEN-1:0] rsp_data;
    logic            busy;

    modport slave (
        input  req0_valid, req1_valid,
        input  req0_instr, req1_instr,
        input  req0_rs1, req0_rs2,
        input  req1_rs1, req1_rs2,
        output req0_ready, req1_ready,
        output alu_instr, alu_rs1, alu_rs2,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req1_valid,
        output req0_instr, req1_instr,
        output req0_rs1, req0_rs2,
        output req1_rs1, req1_rs2,
        input  req0_ready, req1_ready,
        input  alu_instr, alu_rs1, alu_rs2,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready,
        input  busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the favoured requester
// and moves to the loser only when the caller reports a real transfer.
module rr_arb2 (
    input  logic       CLK,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant,
    input  logic       advance
);

    logic r_ptr;

    always_comb begin
        grant = 2'b00;
        if (r_ptr == 1'b0) begin
            if (req[0]) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end
        end else begin
            if (req[1]) begin
                grant = 2'b10;
            end else if (req[0]) begin
                grant = 2'b01;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            r_ptr <= grant[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters and
// registers each result in a single-entry response buffer.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input logic          CLK,
    input logic          reset,
    alu_arbiter_if.slave bus
);

    rsp_state_t      r_state;
    rsp_state_t      w_state_nxt;
    logic [1:0]      w_req;
    logic [1:0]      w_grant;
    logic            w_accept_ok;
    logic            w_xfer;
    req_id_t         w_gnt_id;
    logic [31:0]     w_instr;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    req_id_t         r_rsp_id;
    logic [XLEN-1:0] r_rsp_data;

    assign w_req = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_arb (
        .CLK     (CLK),
        .reset   (reset),
        .req     (w_req),
        .grant   (w_grant),
        .advance (w_xfer)
    );

    // A held response blocks new work unless it drains this same cycle.
    assign w_accept_ok = !reset &&
                         ((r_state == ST_EMPTY) || bus.rsp_ready);
    assign w_xfer      = w_accept_ok && (w_grant != 2'b00);
    assign w_gnt_id    = grant_to_id(w_grant);

    assign bus.req0_ready = w_grant[0] && w_accept_ok;
    assign bus.req1_ready = w_grant[1] && w_accept_ok;

    always_comb begin
        w_instr = '0;
        w_rs1   = '0;
        w_rs2   = '0;
        if (w_grant[0]) begin
            w_instr = bus.req0_instr;
            w_rs1   = bus.req0_rs1;
            w_rs2   = bus.req0_rs2;
        end else if (w_grant[1]) begin
            w_instr = bus.req1_instr;
            w_rs1   = bus.req1_rs1;
            w_rs2   = bus.req1_rs2;
        end
    end

    assign bus.alu_instr = w_instr;
    assign bus.alu_rs1   = w_rs1;
    assign bus.alu_rs2   = w_rs2;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = w_xfer ? ST_FULL : ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else if (w_xfer) begin
            r_rsp_id   <= w_gnt_id;
            r_rsp_data <= bus.alu_result;
        end
    end

    assign bus.rsp_valid = (r_state == ST_FULL);
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = (r_state == ST_FULL);

    a_one_ready: assert property (
        @(posedge CLK) disable iff (reset)
        !(bus.req0_ready && bus.req1_ready)
    );

    a_ready_valid: assert property (
        @(posedge CLK) disable iff (reset)
        (!bus.req0_ready || bus.req0_valid) &&
        (!bus.req1_ready || bus.req1_valid)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against a transaction-level model of the arbiter and response buffer.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errs   = 0;

    // Reference model: pending response, favoured requester.
    bit          m_valid;
    int          m_id;
    logic [31:0] m_data;
    int          m_fav;

    alu_arbiter_if #(.XLEN(32)) bus ();

    alu_arbiter #(.XLEN(32)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(
        input logic [31:0] instr,
        input logic [31:0] a,
        input logic [31:0] b
    );
        R_Type r;
        logic  alt;
        r   = instr;
        alt = r.funct7[5];
        case (r.funct3)
            OP_ADD:  return alt ? a - b : a + b;
            OP_SLL:  return a << b[4:0];
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'd0, a < b};
            OP_XOR:  return a ^ b;
            OP_SR:   return alt ? 32'($signed(a) >>> b[4:0])
                                : a >> b[4:0];
            OP_OR:   return a | b;
            default: return a & b;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_instr,
                                      bus.alu_rs1, bus.alu_rs2);

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        R_Type r;
        r.funct7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        r.rs2    = 5'($urandom);
        r.rs1    = 5'($urandom);
        r.funct3 = 3'($urandom);
        r.rd     = 5'($urandom);
        r.opcode = 7'h33;
        return r;
    endfunction

    // One clock cycle: drive, check combinational outputs, advance
    // the model, then check the registered response after the edge.
    task automatic step(input bit v0,
                        input logic [31:0] i0, a0, b0,
                        input bit v1,
                        input logic [31:0] i1, a1, b1,
                        input bit rr);
        int          win;
        bit          acc;
        logic [31:0] ei, ea, eb;
        bus.req0_valid = v0;
        bus.req0_instr = i0;
        bus.req0_rs1   = a0;
        bus.req0_rs2   = b0;
        bus.req1_valid = v1;
        bus.req1_instr = i1;
        bus.req1_rs1   = a1;
        bus.req1_rs2   = b1;
        bus.rsp_ready  = rr;
        #1;
        acc = !m_valid || rr;
        win = -1;
        if (v0 && v1) win = m_fav;
        else if (v0)  win = 0;
        else if (v1)  win = 1;
        ei = 0; ea = 0; eb = 0;
        if (win == 0) begin ei = i0; ea = a0; eb = b0; end
        if (win == 1) begin ei = i1; ea = a1; eb = b1; end
        chk("req0_ready", bus.req0_ready, (win == 0) && acc);
        chk("req1_ready", bus.req1_ready, (win == 1) && acc);
        chk("alu_instr", bus.alu_instr, ei);
        chk("alu_rs1", bus.alu_rs1, ea);
        chk("alu_rs2", bus.alu_rs2, eb);
        if (win >= 0 && acc) begin
            m_valid = 1;
            m_id    = win;
            m_data  = alu_model(ei, ea, eb);
            m_fav   = 1 - win;
        end else if (rr) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", bus.rsp_valid, m_valid);
        chk("busy", bus.busy, m_valid);
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_data", bus.rsp_data, m_data);
    endtask

    task automatic idle(input bit rr);
        step(0, 0, 0, 0, 0, 0, 0, 0, rr);
    endtask

    // Raise reset off the clock edge, hold it across one edge with
    // both requesters asking, then release and clear the model.
    task automatic apply_reset();
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        bus.rsp_ready  = 1;
        reset = 1'b1;
        #1;
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_data", bus.rsp_data, 0);
        chk("rst_id", bus.rsp_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", bus.rsp_valid, 0);
        chk("rst_hold_ready0", bus.req0_ready, 0);
        reset = 1'b0;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        m_valid = 0;
        m_id    = 0;
        m_data  = 0;
        m_fav   = 0;
    endtask

    initial begin
        logic [31:0] exp_hold;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        bus.req0_instr = 0;
        bus.req1_instr = 0;
        bus.req0_rs1   = 0;
        bus.req0_rs2   = 0;
        bus.req1_rs1   = 0;
        bus.req1_rs2   = 0;
        bus.rsp_ready  = 0;
        #2;
        apply_reset();

        // Single ADD from req0: one-cycle latency.
        step(1, 32'h0000_0033, 5, 7, 0, 0, 0, 0, 1);
        chk("add_valid", bus.rsp_valid, 1);
        chk("add_id", bus.rsp_id, 0);
        chk("add_data", bus.rsp_data, 12);

        // Both requesters every cycle: strict alternation.
        #3;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            step(1, 32'h4000_0033, 10, 3,
                 1, 32'h0000_4033, 32'hF0, 32'hFF, 1);
            chk("alt_id", bus.rsp_id, k % 2);
            chk("alt_data", bus.rsp_data, (k % 2) ? 32'h0F : 32'd7);
        end

        // Backpressure: response held, req1 stalled, then accepted.
        exp_hold = m_data;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 1, 32'h0000_0033, 1, 2, 0);
            chk("hold_data", bus.rsp_data, exp_hold);
            chk("hold_valid", bus.rsp_valid, 1);
        end
        step(0, 0, 0, 0, 1, 32'h0000_0033, 1, 2, 1);
        chk("drain_id", bus.rsp_id, 1);
        chk("drain_data", bus.rsp_data, 3);

        // Reset while holding a result of 12.
        step(1, 32'h0000_0033, 5, 7, 0, 0, 0, 0, 1);
        idle(0);
        chk("pre_rst_data", bus.rsp_data, 12);
        #3;
        apply_reset();
        step(1, 32'h0000_0033, 2, 2, 1, 32'h0000_0033, 4, 4, 1);
        chk("post_rst_id", bus.rsp_id, 0);
        chk("post_rst_data", bus.rsp_data, 4);

        // No requests: zero ALU drive, buffer drains once.
        idle(0);
        chk("idle_full", bus.busy, 1);
        idle(1);
        chk("idle_alu_instr", bus.alu_instr, 0);
        chk("idle_drain", bus.rsp_valid, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_keep", bus.rsp_data, 4);

        // Random traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, rand_instr(),
                 $urandom, $urandom,
                 $urandom_range(0, 3) != 0, rand_instr(),
                 $urandom, $urandom,
                 $urandom_range(0, 9) < 7);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width.
REQ-002 SHALL have port: CLK  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester i presents an ALU op.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  requester i's op accepted this cycle.
REQ-006 SHALL have ports: req0_instr / req1_instr  input  32  R-type instruction word (funct7, funct3 used by ALU).
REQ-007 SHALL have ports: req0_rs1, req0_rs2, req1_rs1, req1_rs2  input  XLEN  operands.
REQ-008 SHALL have ports: alu_instr  output  32; alu_rs1, alu_rs2  output  XLEN; drive the shared combinational ALU.
REQ-009 SHALL have port: alu_result  input  XLEN  combinational ALU output, valid in the same cycle.
REQ-010 SHALL have ports: rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1; rsp_data  output  XLEN.
REQ-011 SHALL have port: busy  output  1  high while a response is held (FULL).

Function
REQ-012 SHALL implement a 2-state FSM on the response register: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
REQ-013 SHALL define accept_ok = EMPTY or (FULL and rsp_ready).
REQ-014 SHALL grant at most one requester per cycle, round-robin: priority pointer names the favoured requester; if only one valid, it wins.
REQ-015 SHALL toggle the pointer to the non-granted requester only on an actual transfer (grant and accept_ok).
REQ-016 SHALL assert reqi_ready = grant_i and accept_ok, combinationally; never for a non-valid requester.
REQ-017 SHALL drive alu_instr/rs1/rs2 from the granted requester; with no grant, drive all zeros.
REQ-018 SHALL on transfer capture alu_result into rsp_data and granted index into rsp_id at the edge; latency 1 cycle, request to rsp_valid.
REQ-019 SHALL on FULL with rsp_ready=1 and a transfer, reload rsp_data/rsp_id and stay FULL (1 op/cycle throughput).
REQ-020 SHALL on FULL with rsp_ready=1 and no transfer, go EMPTY; rsp_data keeps last value.
REQ-021 SHALL on FULL with rsp_ready=0 hold rsp_data, rsp_id, rsp_valid stable and deassert both req_ready.
REQ-022 SHALL not inspect or alter instruction encoding; arithmetic is entirely in the external ALU.
REQ-023 SHALL set busy = (state == FULL).

Reset
REQ-024 SHALL on reset assertion immediately (asynchronously) force: state EMPTY, rsp_valid 0, rsp_id 0, rsp_data 0, pointer favouring req0.
REQ-025 SHALL drop any held or in-flight response on reset mid-operation; no response after reset release until a new transfer.
REQ-026 SHALL keep req_ready low while reset is high.

Structure
REQ-027 SHALL place XLEN default, R_Type typedef, funct3 opcode constants (OP_ADD..OP_AND) and a req_id_t (1-bit) typedef in shared package alu_pkg.
REQ-028 SHALL factor the grant logic and pointer into one sub-module rr_arb2 (2-way round-robin, CLK/reset, req[1:0] in, grant[1:0] out, advance in).
REQ-029 SHALL keep the ALU instance outside this block.

Verification
REQ-030 SHALL test: after reset, req0 valid, instr 0x00000033, rs1=5, rs2=7, ALU model attached -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12.
REQ-031 SHALL test: both valid every cycle, rsp_ready=1, req0 SUB 0x40000033 10,3; req1 XOR 0x00004033 0xF0,0xFF -> responses alternate id 0 (data 7), id 1 (data 0x0F), id 0, ... one per cycle.
REQ-032 SHALL test: FULL, rsp_ready=0 for 3 cycles with req1 valid -> rsp_data/rsp_id stable, req1_ready=0; rsp_ready=1 on 4th cycle -> req1 accepted that cycle, new data next cycle.
REQ-033 SHALL test: reset pulsed mid-cycle while FULL with rsp_data=12 -> rsp_valid=0, rsp_data=0 before next CLK edge; after release, req0 wins first.
REQ-034 SHALL test: no requests valid -> alu_instr/rs1/rs2 all 0, rsp_valid falls after one rsp_ready, busy=0.
